// File: rtl/game_sequencer.sv
// game_sequencer: match-level controller for the pong datapath.
// Walks the ball/score blocks through IDLE, SERVE, RALLY, POINT and OVER.
// It also gates ball motion per frame_tick.
// The optional pause feature is enabled by defining GAME_SEQ_PAUSE_EN.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-low
//   frame_tick   one-cycle pulse per game update
//   start_btn    start button level; a rising edge is a start request
//   pause_btn    pause button level; a rising edge toggles pause (GAME_SEQ_PAUSE_EN only)
//   score_left   left player scored (from ball)
//   score_right  right player scored (from ball)
//   game_over    level from the score module
//   ball_run     ball may advance on frame_tick
//   ball_center  one-cycle recentre pulse
//   serve_dir    0 = serve left, 1 = serve right
//   point_left   one-cycle score increment, left
//   point_right  one-cycle score increment, right
//   flash        playfield invert request
//   state        current state encoding (debug / HEX)
module game_sequencer #(
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int FLASH_PERIOD = 8,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       score_left,
    input  logic       score_right,
    input  logic       game_over,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_dir,
    output logic       point_left,
    output logic       point_right,
    output logic       flash,
    output logic [2:0] state
);
    localparam int FLASH_BIT = $clog2(FLASH_PERIOD);
    localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_FRAMES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        RALLY  = 3'd2,
        POINT  = 3'd3,
        OVER   = 3'd4,
        PAUSED = 3'd5
    } state_t;

    state_t           cur_state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt, cnt_dec;
    logic             start_q, start_req, pause_hit;
    logic             next_dir, next_center, next_pl, next_pr;

    // Counter never wraps: decrement saturates at zero.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    assign start_req = start_btn & ~start_q;
    assign cnt_dec   = sat_dec(cnt);
    assign state     = cur_state;

`ifdef GAME_SEQ_PAUSE_EN
    logic   pause_q;
    state_t ret_state;
    assign pause_hit = pause_btn & ~pause_q;
`else
    logic unused_pause;
    assign unused_pause = pause_btn;
    assign pause_hit    = 1'b0;
`endif

    // A phase ends on the frame_tick that takes the counter to zero, so
    // SERVE/POINT last exactly SERVE_FRAMES/POINT_FRAMES ticks.
    always_comb begin
        next_state  = cur_state;
        next_cnt    = cnt;
        next_dir    = serve_dir;
        next_center = 1'b0;
        next_pl     = 1'b0;
        next_pr     = 1'b0;
        case (cur_state)
            IDLE: begin
                if (start_req) begin
                    next_state  = SERVE;
                    next_center = 1'b1;
                    next_cnt    = SERVE_LOAD;
                end
            end
            SERVE: begin
                if (pause_hit) begin
                    next_state = PAUSED;
                end else if (frame_tick) begin
                    next_cnt = cnt_dec;
                    if (cnt_dec == '0) next_state = RALLY;
                end
            end
            RALLY: begin
                // Left wins a simultaneous score; a score beats a pause request.
                if (score_left) begin
                    next_state = POINT;
                    next_pl    = 1'b1;
                    next_dir   = 1'b1;
                    next_cnt   = POINT_LOAD;
                end else if (score_right) begin
                    next_state = POINT;
                    next_pr    = 1'b1;
                    next_dir   = 1'b0;
                    next_cnt   = POINT_LOAD;
                end else if (pause_hit) begin
                    next_state = PAUSED;
                end
            end
            POINT: begin
                if (frame_tick) begin
                    next_cnt = cnt_dec;
                    if (cnt_dec == '0) begin
                        if (game_over) begin
                            next_state = OVER;
                        end else begin
                            next_state  = SERVE;
                            next_center = 1'b1;
                            next_cnt    = SERVE_LOAD;
                        end
                    end
                end
            end
            OVER: begin
                if (start_req) next_state = IDLE;
            end
`ifdef GAME_SEQ_PAUSE_EN
            PAUSED: begin
                if (pause_hit) next_state = ret_state;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they belong to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state   <= IDLE;
            cnt         <= '0;
            serve_dir   <= 1'b0;
            ball_run    <= 1'b0;
            ball_center <= 1'b0;
            point_left  <= 1'b0;
            point_right <= 1'b0;
            flash       <= 1'b0;
            start_q     <= 1'b1;
`ifdef GAME_SEQ_PAUSE_EN
            pause_q     <= 1'b1;
            ret_state   <= IDLE;
`endif
        end else begin
            cur_state   <= next_state;
            cnt         <= next_cnt;
            serve_dir   <= next_dir;
            ball_run    <= (next_state == RALLY);
            ball_center <= next_center;
            point_left  <= next_pl;
            point_right <= next_pr;
            flash       <= (next_state == POINT) && next_cnt[FLASH_BIT];
            start_q     <= start_btn;
`ifdef GAME_SEQ_PAUSE_EN
            pause_q     <= pause_btn;
            if (next_state == PAUSED && cur_state != PAUSED) ret_state <= cur_state;
`endif
        end
    end
endmodule
